// File: rtl/rv32im_decode_ctrl.sv
// ---------------------------------------------------------------------------
// rv32im_decode_ctrl
//
// Sequencer for the rv32im decode stage. It gates the decode capture strobe,
// holds issue while a control-flow instruction is unresolved, flushes decode
// and fetch on a redirect or an interrupt, inserts interrupts only while the
// pipe is running, and counts stalled fetch cycles for profiling.
//
// Handshake: an instruction is accepted by decode in exactly the cycles where
// fetch_valid_i=1 and decode_ready_o=1. decode_ready_o is combinational and
// never depends on fetch_valid_i being held; fetch may drop valid at any time.
//
// Ports
//   clk_i                 clock, all state on the rising edge
//   clear_i               synchronous active-high reset
//   fetch_valid_i         fetch presents a valid instruction
//   downstream_stall_i    execute/mem/mul not ready; hold issue
//   processing_jump_i     current decode instruction is control-flow
//   jump_resolved_i       execute resolved the outstanding control-flow instr
//   jump_taken_i          qualifies jump_resolved_i: PC redirected
//   interrupt_request_i   level interrupt request
//   decode_ready_o        instruction accepted by decode this cycle
//   decode_clear_o        clear to decode (flush or reset)
//   clear_branch_stall_o  1-cycle pulse on an untaken resolve
//   fetch_flush_o         discard in-flight fetches
//   interrupt_trigger_o   1-cycle pulse; decode latches uepc
//   timeout_o             sticky: a jump wait timed out
//   stall_count_o         saturating count of valid-but-not-accepted cycles
//   dbg_state_o           one-hot state {FLUSH, JUMP_WAIT, RUN}
// ---------------------------------------------------------------------------
module rv32im_decode_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk_i,
    input  logic                clear_i,
    input  logic                fetch_valid_i,
    input  logic                downstream_stall_i,
    input  logic                processing_jump_i,
    input  logic                jump_resolved_i,
    input  logic                jump_taken_i,
    input  logic                interrupt_request_i,
    output logic                decode_ready_o,
    output logic                decode_clear_o,
    output logic                clear_branch_stall_o,
    output logic                fetch_flush_o,
    output logic                interrupt_trigger_o,
    output logic                timeout_o,
    output logic [CNT_BITS-1:0] stall_count_o,
    output logic [2:0]          dbg_state_o
);

    localparam int WT_W = $clog2(WAIT_TIMEOUT);
    localparam int FT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [WT_W-1:0] WT_LAST = WT_W'(WAIT_TIMEOUT - 1);
    localparam logic [WT_W-1:0] WT_ONE  = WT_W'(1);
    localparam logic [FT_W-1:0] FT_LAST = FT_W'(FLUSH_CYCLES - 1);
    localparam logic [FT_W-1:0] FT_ONE  = FT_W'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [2:0] {
        ST_RUN       = 3'b001,
        ST_JUMP_WAIT = 3'b010,
        ST_FLUSH     = 3'b100
    } state_t;

    state_t              state;
    logic [WT_W-1:0]     wait_timer;
    logic [FT_W-1:0]     flush_timer;
    logic [CNT_BITS-1:0] stall_cnt;
    logic                timeout_q;

    logic in_run;
    logic in_wait;
    logic in_flush;
    logic resolve_taken;
    logic resolve_untaken;
    logic stall_inc;

    assign in_run   = (state == ST_RUN);
    assign in_wait  = (state == ST_JUMP_WAIT);
    assign in_flush = (state == ST_FLUSH);

    // A pending interrupt blocks issue so the instruction stream is cut
    // cleanly at the point the trigger fires.
    assign decode_ready_o = in_run & fetch_valid_i & ~downstream_stall_i
                            & ~interrupt_request_i;

    // Resolves are only meaningful while a control-flow instr is in flight.
    assign resolve_taken   = in_wait & jump_resolved_i & jump_taken_i;
    assign resolve_untaken = in_wait & jump_resolved_i & ~jump_taken_i;

    // Pulses are suppressed in a reset cycle so an abandoned operation
    // never leaks a side effect into decode.
    assign interrupt_trigger_o  = in_run & interrupt_request_i & ~clear_i;
    assign clear_branch_stall_o = resolve_untaken & ~clear_i;

    assign fetch_flush_o  = in_flush;
    assign decode_clear_o = clear_i | in_flush;

    assign timeout_o     = timeout_q;
    assign stall_count_o = stall_cnt;
    assign dbg_state_o   = state;

    assign stall_inc = fetch_valid_i & ~decode_ready_o;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state       <= ST_RUN;
            wait_timer  <= '0;
            flush_timer <= '0;
            stall_cnt   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // Saturate rather than wrap so long stalls read as "at least max".
            if (stall_inc && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end

            case (state)
                ST_RUN: begin
                    if (interrupt_request_i) begin
                        state       <= ST_FLUSH;
                        flush_timer <= '0;
                    end else if (decode_ready_o && processing_jump_i) begin
                        state      <= ST_JUMP_WAIT;
                        wait_timer <= '0;
                    end
                end

                ST_JUMP_WAIT: begin
                    // A resolve on the final wait cycle takes priority over
                    // the timeout, so timeout_o only flags genuine hangs.
                    if (resolve_taken) begin
                        state       <= ST_FLUSH;
                        flush_timer <= '0;
                    end else if (resolve_untaken) begin
                        state <= ST_RUN;
                    end else if (wait_timer == WT_LAST) begin
                        timeout_q   <= 1'b1;
                        state       <= ST_FLUSH;
                        flush_timer <= '0;
                    end else begin
                        wait_timer <= wait_timer + WT_ONE;
                    end
                end

                ST_FLUSH: begin
                    if (flush_timer == FT_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        flush_timer <= flush_timer + FT_ONE;
                    end
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32im_decode_ctrl
//
// Drives rv32im_decode_ctrl one cycle at a time and compares every output
// against a behavioural model kept here: the model tracks "waiting on a
// jump" with an age counter, "flushing" with a remaining-cycles count and
// the profiling counter as a plain integer. Directed scenarios are followed
// by a randomized run.
// ---------------------------------------------------------------------------
module tb_rv32im_decode_ctrl;

    localparam int FC  = 2;
    localparam int WT  = 4;
    localparam int CB  = 4;
    localparam int CNT_MAX = (1 << CB) - 1;

    logic          clk;
    logic          clear;
    logic          fetch_valid;
    logic          downstream_stall;
    logic          processing_jump;
    logic          jump_resolved;
    logic          jump_taken;
    logic          interrupt_request;
    logic          decode_ready;
    logic          decode_clear;
    logic          clear_branch_stall;
    logic          fetch_flush;
    logic          interrupt_trigger;
    logic          timeout;
    logic [CB-1:0] stall_count;
    logic [2:0]    dbg_state;

    rv32im_decode_ctrl #(
        .FLUSH_CYCLES(FC),
        .WAIT_TIMEOUT(WT),
        .CNT_BITS    (CB)
    ) dut (
        .clk_i               (clk),
        .clear_i             (clear),
        .fetch_valid_i       (fetch_valid),
        .downstream_stall_i  (downstream_stall),
        .processing_jump_i   (processing_jump),
        .jump_resolved_i     (jump_resolved),
        .jump_taken_i        (jump_taken),
        .interrupt_request_i (interrupt_request),
        .decode_ready_o      (decode_ready),
        .decode_clear_o      (decode_clear),
        .clear_branch_stall_o(clear_branch_stall),
        .fetch_flush_o       (fetch_flush),
        .interrupt_trigger_o (interrupt_trigger),
        .timeout_o           (timeout),
        .stall_count_o       (stall_count),
        .dbg_state_o         (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    // observed-event tallies used by the directed scenarios
    int obs_cbs   = 0;
    int obs_int   = 0;
    int obs_flush = 0;
    int obs_ready = 0;

    // ---------------- reference model state ----------------
    bit m_known      = 1'b0;  // model meaningful once a reset has been applied
    bit m_waiting    = 1'b0;
    int m_wait_age   = 0;
    int m_flush_left = 0;
    bit m_timeout    = 1'b0;
    int m_stall      = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_tallies();
        obs_cbs   = 0;
        obs_int   = 0;
        obs_flush = 0;
        obs_ready = 0;
    endtask

    // One clock cycle: apply inputs, compare outputs, clock, advance model.
    task automatic step(input logic fv, input logic ds, input logic pj,
                        input logic res, input logic tk, input logic irq,
                        input logic clr);
        bit e_run, e_flush, e_ready, e_int, e_cbs, e_dclr;
        fetch_valid       = fv;
        downstream_stall  = ds;
        processing_jump   = pj;
        jump_resolved     = res;
        jump_taken        = tk;
        interrupt_request = irq;
        clear             = clr;
        #1;
        e_flush = (m_flush_left > 0);
        e_run   = !m_waiting && !e_flush;
        e_ready = e_run && fv && !ds && !irq;
        e_int   = e_run && irq && !clr;
        e_cbs   = m_waiting && res && !tk && !clr;
        e_dclr  = clr || e_flush;

        check("decode_clear", 32'(decode_clear), 32'(e_dclr));
        if (m_known) begin
            check("decode_ready",       32'(decode_ready),       32'(e_ready));
            check("fetch_flush",        32'(fetch_flush),        32'(e_flush));
            check("interrupt_trigger",  32'(interrupt_trigger),  32'(e_int));
            check("clear_branch_stall", 32'(clear_branch_stall), 32'(e_cbs));
            check("timeout",            32'(timeout),            32'(m_timeout));
            check("stall_count",        32'(stall_count),        32'(m_stall));
            check("dbg_state",          32'(dbg_state),
                  32'({e_flush, m_waiting, e_run}));
        end

        obs_cbs   += int'(clear_branch_stall);
        obs_int   += int'(interrupt_trigger);
        obs_flush += int'(fetch_flush && decode_clear);
        obs_ready += int'(decode_ready);

        @(posedge clk);
        if (clr) begin
            m_known      = 1'b1;
            m_waiting    = 1'b0;
            m_wait_age   = 0;
            m_flush_left = 0;
            m_timeout    = 1'b0;
            m_stall      = 0;
        end else begin
            if (fv && !e_ready && m_stall < CNT_MAX) m_stall++;
            if (e_run) begin
                if (irq) m_flush_left = FC;
                else if (e_ready && pj) begin
                    m_waiting  = 1'b1;
                    m_wait_age = 0;
                end
            end else if (m_waiting) begin
                if (res) begin
                    m_waiting = 1'b0;
                    if (tk) m_flush_left = FC;
                end else if (m_wait_age == WT - 1) begin
                    m_waiting    = 1'b0;
                    m_timeout    = 1'b1;
                    m_flush_left = FC;
                end else begin
                    m_wait_age++;
                end
            end else begin
                m_flush_left--;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fetch_valid = 0; downstream_stall = 0; processing_jump = 0;
        jump_resolved = 0; jump_taken = 0; interrupt_request = 0; clear = 1;

        // 1: straight-line issue after reset
        do_reset();
        check("rst_stall_count", 32'(stall_count), 32'd0);
        check("rst_state_run",   32'(dbg_state),   32'b001);
        check("rst_timeout",     32'(timeout),     32'd0);
        clear_tallies();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("t1_ready_cycles", 32'(obs_ready),   32'd5);
        check("t1_stall_count",  32'(stall_count), 32'd0);

        // 2: untaken branch resolved on the third wait cycle
        do_reset();
        clear_tallies();
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        check("t2_cbs_pulses",  32'(obs_cbs),     32'd1);
        check("t2_stall_count", 32'(stall_count), 32'd3);
        check("t2_state_run",   32'(dbg_state),   32'b001);
        clear_tallies();
        step(1, 0, 0, 0, 0, 0, 0);
        check("t2_issue_after", 32'(obs_ready), 32'd1);

        // 3: taken JAL, flush for FC cycles then issue again
        do_reset();
        step(1, 0, 1, 0, 0, 0, 0);
        clear_tallies();
        step(1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("t3_flush_cycles", 32'(obs_flush), 32'd2);
        check("t3_ready_after",  32'(obs_ready), 32'd1);

        // 4: interrupt deferred across a jump wait
        do_reset();
        step(1, 0, 1, 0, 0, 0, 0);
        clear_tallies();
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        check("t4_no_trigger_wait", 32'(obs_int), 32'd0);
        step(1, 0, 0, 0, 0, 1, 0);
        check("t4_trigger_once", 32'(obs_int), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t4_flush_cycles", 32'(obs_flush), 32'd2);
        check("t4_back_run",     32'(dbg_state), 32'b001);

        // 5: timeout, then resolve on the timeout cycle
        do_reset();
        step(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        check("t5_timeout_set", 32'(timeout),   32'd1);
        check("t5_in_flush",    32'(dbg_state), 32'b100);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t5_back_run",    32'(dbg_state), 32'b001);
        do_reset();
        step(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t5_timeout_clear", 32'(timeout),   32'd0);
        check("t5_resolve_run",   32'(dbg_state), 32'b001);

        // 6: counter saturation, then reset in the middle of a flush
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0);
        check("t6_saturate", 32'(stall_count), 32'd15);
        step(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        check("t6_timeout_pre", 32'(timeout), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t6_rst_state", 32'(dbg_state),   32'b001);
        check("t6_rst_count", 32'(stall_count), 32'd0);
        check("t6_rst_tmo",   32'(timeout),     32'd0);

        // randomized run against the model
        for (int i = 0; i < 800; i++) begin
            step(logic'($urandom_range(0, 99) < 80),
                 logic'($urandom_range(0, 99) < 20),
                 logic'($urandom_range(0, 99) < 40),
                 logic'($urandom_range(0, 99) < 30),
                 logic'($urandom_range(0, 99) < 50),
                 logic'($urandom_range(0, 99) < 8),
                 logic'($urandom_range(0, 99) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
